pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch/issue sequencer for a small program ROM.
// Resolves NOP/JUMP/CJUMP/HALT locally and hands all other opcodes to the
// datapath with an ex_valid/ex_done handshake.
// Optional feature: define SEQ_SINGLE_STEP_EN to add step_mode/step inputs
// that gate FETCH so a debugger can advance one instruction per step pulse.
module pc_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] instr,
   output logic [5:0]  pc,
   output logic        ex_valid,
   output logic [15:0] ex_instr,
   input  logic        ex_done,
   input  logic        cond_true,
   input  logic [7:0]  tgt_val,
   output logic        halted,
   output logic [15:0] retired
`ifdef SEQ_SINGLE_STEP_EN
   ,
   input  logic        step_mode,
   input  logic        step
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_JUMP  = 4'hA;
   localparam logic [3:0] OP_CJUMP = 4'hC;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_t      state_q, state_d;
   logic [5:0]  pc_q, pc_d;
   logic [15:0] ex_instr_q, ex_instr_d;
   logic [15:0] retired_q, retired_d;
   logic        halted_q, halted_d;

   logic [3:0]  opcode;
   logic        is_ctrl;
   logic        fetch_go;
   logic [5:0]  pc_inc;
   logic [15:0] retired_inc;

   // Only the low six target bits address the ROM; unused instr fields are
   // decoded by the datapath, not here.
   logic        unused_bits;
   assign unused_bits = ^{tgt_val[7:6], ex_instr_q[15:14], ex_instr_q[7:4]};

   assign opcode      = ex_instr_q[3:0];
   assign is_ctrl     = (opcode == OP_NOP) || (opcode == OP_JUMP) ||
                        (opcode == OP_CJUMP) || (opcode == OP_HALT);
   assign pc_inc      = pc_q + 6'd1;   // 63 -> 0 wrap is intended
   assign retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

`ifdef SEQ_SINGLE_STEP_EN
   assign fetch_go = !step_mode || step;
`else
   assign fetch_go = 1'b1;
`endif

   // Issue request depends on current state only, so reset drops it at once.
   assign ex_valid = (state_q == S_ISSUE) && !is_ctrl;
   assign pc       = pc_q;
   assign ex_instr = ex_instr_q;
   assign retired  = retired_q;
   assign halted   = halted_q;

   // Next-state, next-pc and retire-count computation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ex_instr_d = ex_instr_q;
      retired_d  = retired_q;
      case (state_q)
         S_IDLE: begin
            pc_d = 6'd0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (fetch_go) begin
               ex_instr_d = instr;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            case (opcode)
               OP_NOP: begin
                  pc_d      = pc_inc;
                  state_d   = S_FETCH;
                  retired_d = retired_inc;
               end
               OP_JUMP: begin
                  pc_d      = ex_instr_q[13:8];
                  state_d   = S_FETCH;
                  retired_d = retired_inc;
               end
               OP_CJUMP: begin
                  pc_d      = cond_true ? tgt_val[5:0] : pc_inc;
                  state_d   = S_FETCH;
                  retired_d = retired_inc;
               end
               OP_HALT: begin
                  state_d   = S_HALT;
                  retired_d = retired_inc;
               end
               default: begin
                  if (ex_done) begin
                     pc_d      = pc_inc;
                     state_d   = S_FETCH;
                     retired_d = retired_inc;
                  end
               end
            endcase
         end
         S_HALT: begin
            if (start) begin
               pc_d      = 6'd0;
               retired_d = 16'd0;
               state_d   = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
      halted_d = (state_d == S_HALT);
   end

   // Sequencer state register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= 6'd0;
         ex_instr_q <= 16'h0000;
         retired_q  <= 16'd0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ex_instr_q <= ex_instr_d;
         retired_q  <= retired_d;
         halted_q   <= halted_d;
      end
   end

endmodule
